// File: rtl/out_writer_if.sv
// ---------------------------------------------------------------------------
// out_writer_if -- job control, accumulator stream and output-buffer write
// port of the out_writer block.
//
// Signals
//   start      job launch pulse (master -> slave)
//   m, n       output rows / columns for the job (master -> slave)
//   acc_valid  one tile row of four accumulators is presented (master -> slave)
//   acc_data   four signed accumulators, column 0 in the low ACC_SIZE bits
//   acc_ready  slave accepts acc_data this cycle (slave -> master)
//   wr_en      output global-buffer write strobe (slave -> master)
//   wr_addr    output global-buffer word address (slave -> master)
//   wr_data    packed output word, tile column 0 in the low byte
//   done       job complete (slave -> master)
// ---------------------------------------------------------------------------
interface out_writer_if #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_SIZE  = 16,
    parameter int ADDR_BITS = 8
);
    logic                   start;
    logic [3:0]             m;
    logic [3:0]             n;
    logic                   acc_valid;
    logic [4*ACC_SIZE-1:0]  acc_data;
    logic                   acc_ready;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   wr_addr;
    logic [4*DATA_SIZE-1:0] wr_data;
    logic                   done;

    modport master (
        output start, m, n, acc_valid, acc_data,
        input  acc_ready, wr_en, wr_addr, wr_data, done
    );

    modport slave (
        input  start, m, n, acc_valid, acc_data,
        output acc_ready, wr_en, wr_addr, wr_data, done
    );
endinterface

// File: rtl/out_writer.sv
// ---------------------------------------------------------------------------
// out_writer -- drains systolic-array output rows (4 columns per tile) into
// the output global buffer, one packed word per accepted row.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    out_writer_if.slave: start/m/n job control, acc_valid/acc_ready/
//          acc_data input stream, wr_en/wr_addr/wr_data buffer write, done
//
// Configuration
//   OUT_WRITER_SAT_EN  defined: each lane saturates to the signed DATA_SIZE
//                      range; undefined: each lane keeps its low DATA_SIZE bits.
// ---------------------------------------------------------------------------
module out_writer #(
    parameter int DATA_SIZE = 8,
    parameter int ACC_SIZE  = 16,
    parameter int ADDR_BITS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    out_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             row_q, row_d;
    logic [1:0]             tile_q, tile_d;
    logic [3:0]             m_q, m_d;
    logic [3:0]             n_q, n_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [4*DATA_SIZE-1:0] wr_data_q, wr_data_d;

    logic [7:0]             addr_full;
    logic [4*DATA_SIZE-1:0] lane_word;
    logic                   beat;
    logic                   last_row;
    logic                   last_tile;

`ifdef OUT_WRITER_SAT_EN
    localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((1 << (DATA_SIZE - 1)) - 1);
    localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic [DATA_SIZE-1:0] sat_lane(input logic [ACC_SIZE-1:0] v);
        if ($signed(v) > SAT_MAX) begin
            return {1'b0, {(DATA_SIZE - 1){1'b1}}};
        end else if ($signed(v) < SAT_MIN) begin
            return {1'b1, {(DATA_SIZE - 1){1'b0}}};
        end
        return v[DATA_SIZE-1:0];
    endfunction
`else
    // Truncation drops the accumulator high bits.
    logic acc_hi_unused;
    assign acc_hi_unused = ^bus.acc_data;
`endif

    // Word address is tile*m + row; max 3*15+14 fits in 8 bits before resizing.
    assign addr_full = 8'(tile_q) * 8'(m_q) + 8'(row_q);
    assign beat      = (state_q == BUSY) && bus.acc_valid;
    assign last_row  = (row_q == m_q - 4'd1);
    // Last tile index is (n-1)/4; n is nonzero whenever BUSY.
    assign last_tile = (tile_q == 2'((n_q - 4'd1) >> 2));

    // Lanes past column n-1 of a partial tile are written as zero.
    always_comb begin
        lane_word = '0;
        for (int unsigned lane = 0; lane < 4; lane++) begin
            if ({tile_q, 2'(lane)} < n_q) begin
`ifdef OUT_WRITER_SAT_EN
                lane_word[lane*DATA_SIZE +: DATA_SIZE] =
                    sat_lane(bus.acc_data[lane*ACC_SIZE +: ACC_SIZE]);
`else
                lane_word[lane*DATA_SIZE +: DATA_SIZE] =
                    bus.acc_data[lane*ACC_SIZE +: DATA_SIZE];
`endif
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        tile_d    = tile_q;
        m_d       = m_q;
        n_d       = n_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    m_d     = bus.m;
                    n_d     = bus.n;
                    row_d   = '0;
                    tile_d  = '0;
                    state_d = (bus.m == 4'd0 || bus.n == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (beat) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_BITS'(addr_full);
                    wr_data_d = lane_word;
                    if (last_row) begin
                        row_d = '0;
                        if (last_tile) begin
                            state_d = DONE;
                        end else begin
                            tile_d = tile_q + 2'd1;
                        end
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            tile_q    <= '0;
            m_q       <= '0;
            n_q       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            tile_q    <= tile_d;
            m_q       <= m_d;
            n_q       <= n_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.acc_ready = (state_q == BUSY);
    assign bus.done      = (state_q == DONE);
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_out_writer.sv
module tb_out_writer;

    localparam int DS = 8;
    localparam int AS = 16;
    localparam int AB = 8;

    typedef struct {
        logic [AB-1:0]   addr;
        logic [4*DS-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    wr_t  exp_q[$];

    out_writer_if #(.DATA_SIZE(DS), .ACC_SIZE(AS), .ADDR_BITS(AB)) bus ();

    out_writer #(.DATA_SIZE(DS), .ACC_SIZE(AS), .ADDR_BITS(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference lane conversion from the signed value.
    function automatic logic [7:0] conv(input logic [15:0] v);
`ifdef OUT_WRITER_SAT_EN
        int s;
        s = int'($signed(v));
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
`endif
        return v[7:0];
    endfunction

    // Beat k of a job is row k%m of tile k/m; its address is simply k.
    function automatic logic [31:0] exp_word(input logic [63:0] d, input int k, input int mm, input int nn);
        logic [31:0] w;
        int tile;
        w = '0;
        tile = k / mm;
        for (int l = 0; l < 4; l++) begin
            if (tile * 4 + l < nn) w[l*8 +: 8] = conv(d[l*16 +: 16]);
        end
        return w;
    endfunction

    function automatic logic [63:0] rand_beat();
        logic [63:0] d;
        logic [15:0] v;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            case ($urandom_range(3, 0))
                0: v = 16'($urandom);
                1: v = 16'($urandom_range(255, 0)) - 16'd128;
                2: begin
                    case ($urandom_range(5, 0))
                        0: v = 16'd127;
                        1: v = 16'd128;
                        2: v = 16'hFF80;
                        3: v = 16'hFF7F;
                        4: v = 16'h7FFF;
                        default: v = 16'h8000;
                    endcase
                end
                default: v = 16'($urandom_range(127, 0));
            endcase
            d[l*16 +: 16] = v;
        end
        return d;
    endfunction

    // Scoreboard monitor: every write must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {bus.wr_addr, bus.wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                    check("wr_data", 64'(bus.wr_data), 64'(e.data));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send_beat(input logic [63:0] d, input int k, input int jm, input int jn, output bit ok);
        wr_t e;
        bus.acc_valid = 1'b1;
        bus.acc_data  = d;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.acc_ready === 1'b1) begin
                ok = 1'b1;
                e.addr = AB'(k);
                e.data = exp_word(d, k, jm, jn);
                exp_q.push_back(e);
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.acc_valid = 1'b0;
        if (!ok) check("beat_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_job(input int jm, input int jn, input int gap_lo, input int gap_hi,
                           input bit busy_start, input bit use_fixed, input logic [63:0] fixed);
        int  beats;
        int  wc0;
        int  g;
        bit  ok;
        beats = jm * ((jn + 3) / 4);
        wc0   = wr_cnt;
        bus.start = 1'b1;
        bus.m     = 4'(jm);
        bus.n     = 4'(jn);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (beats == 0) begin
            check("zero_job_done", {62'd0, bus.done, bus.acc_ready}, 64'b10);
            repeat (3) @(posedge clk);
            #1;
            check("zero_job_writes", 64'(wr_cnt - wc0), 64'd0);
            return;
        end
        check("busy_entry", {62'd0, bus.acc_ready, bus.done}, 64'b10);
        for (int k = 0; k < beats; k++) begin
            send_beat(use_fixed ? fixed : rand_beat(), k, jm, jn, ok);
            if (!ok) return;
            if (k == beats - 1) begin
                check("final_write_done", {61'd0, bus.wr_en, bus.done, bus.acc_ready}, 64'b110);
            end else begin
                if (busy_start && k == 0) begin
                    bus.start = 1'b1;
                    bus.m     = 4'd1;
                    bus.n     = 4'd0;
                    @(posedge clk);
                    #1;
                    bus.start = 1'b0;
                    check("start_in_busy_ignored", {62'd0, bus.acc_ready, bus.done}, 64'b10);
                end
                g = $urandom_range(gap_hi, gap_lo);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
        end
        @(negedge clk);
        #1;
        check("write_count", 64'(wr_cnt - wc0), 64'(beats));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        // acc_valid in DONE must not write or disturb state.
        bus.acc_valid = 1'b1;
        bus.acc_data  = rand_beat();
        repeat (2) @(posedge clk);
        #1;
        bus.acc_valid = 1'b0;
        check("done_hold", {62'd0, bus.done, bus.acc_ready}, 64'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int jm;
        int jn;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.m         = '0;
        bus.n         = '0;
        bus.acc_valid = 1'b0;
        bus.acc_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({bus.acc_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // n == 0 straight after reset: DONE with no writes.
        run_job(1, 0, 0, 0, 0, 0, '0);
        // Full tile, lanes 1..4.
        run_job(4, 4, 0, 0, 0, 1, 64'h0004_0003_0002_0001);
        // Partial second tile: upper two lanes zeroed.
        run_job(2, 6, 0, 0, 0, 1, 64'h0055_0044_0033_0022);
        // Saturation / truncation boundary values.
        run_job(1, 4, 0, 0, 0, 1, 64'hFF00_0190_FF00_0190);
        // acc_valid toggling 1,0,1,0.
        run_job(3, 8, 1, 1, 0, 0, '0);
        // start pulse during BUSY.
        run_job(4, 5, 0, 1, 1, 0, '0);
        // m == 0 from DONE.
        run_job(0, 7, 0, 0, 0, 0, '0);

        // Reset after the second beat of a 4-row job.
        bus.start = 1'b1;
        bus.m     = 4'd4;
        bus.n     = 4'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            send_beat(rand_beat(), k, 4, 4, ok);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero",
              64'({bus.acc_ready, bus.wr_en, bus.wr_addr, bus.wr_data, bus.done}), 64'd0);
        bus.acc_valid = 1'b1;
        bus.acc_data  = rand_beat();
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.acc_valid = 1'b0;
        check("abort_no_pending", 64'(exp_q.size()), 64'd0);
        rst_n = 1'b1;
        run_job(4, 4, 0, 1, 0, 0, '0);

        // Randomised jobs.
        for (int j = 0; j < 20; j++) begin
            jm = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(15, 1));
            jn = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(15, 1));
            run_job(jm, jn, 0, 2, $urandom_range(1, 0) == 1, 0, '0);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/out_writer.md
OUT_WRITER -- requirements
Module: out_writer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 8, output element width in bits.
REQ-002 SHALL have parameter ACC_SIZE, default 16, signed accumulator width per systolic-array column.
REQ-003 SHALL have parameter ADDR_BITS, default 8, output global-buffer address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that launches a job.
REQ-007 SHALL have port m  input  4  number of output rows.
REQ-008 SHALL have port n  input  4  number of output columns.
REQ-009 SHALL have port acc_valid  input  1  the systolic array presents one output row of a 4-column tile.
REQ-010 SHALL have port acc_data  input  4*ACC_SIZE  four signed accumulators; column 0 in bits [ACC_SIZE-1:0].
REQ-011 SHALL have port acc_ready  output  1  the block accepts acc_data this cycle.
REQ-012 SHALL have port wr_en  output  1  write strobe to the output global buffer.
REQ-013 SHALL have port wr_addr  output  ADDR_BITS  output global-buffer word address.
REQ-014 SHALL have port wr_data  output  4*DATA_SIZE  packed word; tile column 0 in [7:0], column 3 in [31:24].
REQ-015 SHALL have port done  output  1  job complete.

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE; start in IDLE or DONE latches m and n, clears counters and enters BUSY; start in BUSY is ignored.
REQ-017 SHALL transition start with m==0 or n==0 directly to DONE with no writes.
REQ-018 SHALL process tiles = ceil(n/4); beats arrive row-major: rows 0..m-1 of tile 0, then tile 1, and so on.
REQ-019 SHALL drive acc_ready=1 only in BUSY; a beat transfers when acc_valid && acc_ready.
REQ-020 SHALL, for each transferred beat, pulse wr_en exactly one cycle later, with wr_addr = tile*m + row (zero-extended, modulo 2^ADDR_BITS).
REQ-021 SHALL force output lanes whose column index tile*4+lane >= n to 8'h00.
REQ-022 SHALL convert each lane per REQ-033/REQ-034.
REQ-023 SHALL advance row, wrapping to 0 and incrementing tile at m-1; the last beat (tile==tiles-1, row==m-1) deasserts acc_ready in the following cycle and enters DONE in that same cycle as its write.
REQ-024 SHALL hold done=1 in DONE until the next accepted start, which clears it in the next cycle.
REQ-025 SHALL keep wr_en=0 in IDLE and DONE except for the final write of REQ-023.
REQ-026 SHALL ignore acc_valid outside BUSY with no state change.

Reset
REQ-027 SHALL, on rst_n low, asynchronously enter IDLE regardless of current state, including mid-job.
REQ-028 SHALL reset acc_ready=0, wr_en=0, wr_addr=0, wr_data=0 and done=0.
REQ-029 SHALL clear the row, tile, latched m and latched n registers to 0 on reset.
REQ-030 SHALL accept start in the first clock edge after rst_n deasserts.
REQ-031 SHALL not complete a pending write when reset aborts a job.

Configuration
REQ-032 SHALL compile the saturation feature in or out with macro OUT_WRITER_SAT_EN.
REQ-033 SHALL, with OUT_WRITER_SAT_EN defined, clamp each signed lane to [-128, 127]: >127 -> 8'h7F, <-128 -> 8'h80.
REQ-034 SHALL, without OUT_WRITER_SAT_EN, truncate each lane to its low DATA_SIZE bits.

Verification
REQ-035 SHALL cover m=4, n=4, four beats with lane values 1,2,3,4 per row -> writes to addresses 0..3, each wr_data=32'h04030201; done=1 on the final write cycle.
REQ-036 SHALL cover m=2, n=6 -> four writes at addresses 0,1,2,3; at addresses 2 and 3, bytes [31:16]=16'h0000.
REQ-037 SHALL cover a lane value of 16'h0190 (400) -> lane byte 8'h7F with OUT_WRITER_SAT_EN defined and 8'h90 without; a lane value of 16'hFF00 (-256) -> 8'h80 with the macro and 8'h00 without.
REQ-038 SHALL cover acc_valid toggling 1,0,1,0 in BUSY -> exactly one wr_en pulse per transfer, addresses contiguous.
REQ-039 SHALL cover rst_n low after the 2nd beat of a 4-row job -> all outputs 0 immediately, no further wr_en, and the next start runs a full job correctly.
REQ-040 SHALL cover start with n=0 -> done=1 one cycle later with zero writes; start during BUSY -> ignored.
